multicycle_ctrl: RTL and testbench

Multicycle control FSM for the RV32 datapath. It sequences fetch, decode, execute, memory and writeback by driving the PC, IR, memory and register-file enables and the datapath mux selects. It decodes opcode from the IR output and branch_taken from the ALU compare. It counts retired instructions and halts on an illegal opcode.

---
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and the RV32 datapath.
// The controller takes the master view: it drives every enable and mux select
// and reads back the decoded opcode, the branch compare and the memory handshake.
interface multicycle_ctrl_if #(
    parameter int WIDTH = 32
);
    // Datapath -> controller
    logic [6:0]       opcode;
    logic             branch_taken;
    logic             mem_ready;
    // Controller -> datapath
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             ir_en;
    logic             mem_addr_sel;
    logic             mem_wren;
    logic             rf_wr_en;
    logic [1:0]       wb_sel;
    logic             alu_b_sel;
    logic             alu_force_add;
    logic             halted;
    logic [WIDTH-1:0] instret;

    modport master (
        input  opcode, branch_taken, mem_ready,
        output pc_en, pc_src, ir_en, mem_addr_sel, mem_wren, rf_wr_en,
               wb_sel, alu_b_sel, alu_force_add, halted, instret
    );

    modport slave (
        output opcode, branch_taken, mem_ready,
        input  pc_en, pc_src, ir_en, mem_addr_sel, mem_wren, rf_wr_en,
               wb_sel, alu_b_sel, alu_force_add, halted, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/memory/writeback,
// counts retired instructions and parks in HALT on an unsupported opcode.
// Outputs are decoded combinationally from the state register and the IR opcode.
module multicycle_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_if.master     bus
);
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_HOLD   = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] instret_q, instret_d;
    logic             retire_s;

    logic             pc_en_s;
    logic [1:0]       pc_src_s;
    logic             ir_en_s;
    logic             mem_addr_sel_s;
    logic             mem_wren_s;
    logic             rf_wr_en_s;
    logic [1:0]       wb_sel_s;
    logic             alu_b_sel_s;
    logic             alu_force_add_s;
    logic             halted_s;

    // Next-state, retire pulse and datapath controls for the current state.
    always_comb begin
        state_d         = state_q;
        retire_s        = 1'b0;
        pc_en_s         = 1'b0;
        pc_src_s        = PC_HOLD;
        ir_en_s         = 1'b0;
        mem_addr_sel_s  = 1'b0;
        mem_wren_s      = 1'b0;
        rf_wr_en_s      = 1'b0;
        wb_sel_s        = WB_ALU;
        alu_b_sel_s     = 1'b0;
        alu_force_add_s = 1'b0;
        halted_s        = 1'b0;

        if (rst) begin
            // Everything parked at its idle value; the instruction in flight is dropped.
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir_en_s  = 1'b1;
                        pc_en_s  = 1'b1;
                        pc_src_s = PC_PLUS4;
                        state_d  = S_DECODE;
                    end else begin
                        state_d  = S_FETCH;
                    end
                end
                S_DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE, OP_IALU:  state_d = S_EXEC;
                        OP_LOAD, OP_STORE:  state_d = S_ADDR;
                        OP_BRANCH:          state_d = S_BRANCH;
                        OP_JAL:             state_d = S_JUMP;
                        default:            state_d = S_HALT;
                    endcase
                end
                S_EXEC: begin
                    alu_b_sel_s = (bus.opcode == OP_IALU) ? 1'b1 : 1'b0;
                    rf_wr_en_s  = 1'b1;
                    wb_sel_s    = WB_ALU;
                    retire_s    = 1'b1;
                    state_d     = S_FETCH;
                end
                S_ADDR: begin
                    alu_force_add_s = 1'b1;
                    alu_b_sel_s     = 1'b1;
                    state_d         = S_MEM;
                end
                S_MEM: begin
                    // Address path held stable for the whole access.
                    mem_addr_sel_s  = 1'b1;
                    alu_force_add_s = 1'b1;
                    alu_b_sel_s     = 1'b1;
                    if (bus.opcode == OP_STORE) begin
                        mem_wren_s = 1'b1;
                        if (bus.mem_ready) begin
                            retire_s = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d  = S_MEM;
                        end
                    end else begin
                        if (bus.mem_ready) begin
                            state_d = S_WB;
                        end else begin
                            state_d = S_MEM;
                        end
                    end
                end
                S_WB: begin
                    rf_wr_en_s = 1'b1;
                    wb_sel_s   = WB_MEM;
                    retire_s   = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    if (bus.branch_taken) begin
                        pc_en_s  = 1'b1;
                        pc_src_s = PC_TARGET;
                    end else begin
                        pc_en_s  = 1'b0;
                    end
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end
                S_JUMP: begin
                    pc_en_s    = 1'b1;
                    pc_src_s   = PC_TARGET;
                    rf_wr_en_s = 1'b1;
                    wb_sel_s   = WB_PC4;
                    retire_s   = 1'b1;
                    state_d    = S_FETCH;
                end
                S_HALT: begin
                    halted_s = 1'b1;
                    state_d  = S_HALT;
                end
                default: begin
                    // Unreachable encodings recover through a fresh fetch.
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // Retired-instruction counter, wrapping modulo 2^WIDTH.
    always_comb begin
        if (retire_s) begin
            instret_d = instret_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            instret_d = instret_q;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign bus.pc_en         = pc_en_s;
    assign bus.pc_src        = pc_src_s;
    assign bus.ir_en         = ir_en_s;
    assign bus.mem_addr_sel  = mem_addr_sel_s;
    assign bus.mem_wren      = mem_wren_s;
    assign bus.rf_wr_en      = rf_wr_en_s;
    assign bus.wb_sel        = wb_sel_s;
    assign bus.alu_b_sel     = alu_b_sel_s;
    assign bus.alu_force_add = alu_force_add_s;
    assign bus.halted        = halted_s;
    assign bus.instret       = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. The driver pushes one hand-computed
// expectation per cycle into a queue; a monitor on the falling edge pops it and
// compares the control vector and instret against the live DUT outputs.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    multicycle_ctrl_if #(.WIDTH(32)) bus();

    multicycle_ctrl #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Control vector: {pc_en, pc_src[1:0], ir_en, mem_addr_sel, mem_wren,
    //                  rf_wr_en, wb_sel[1:0], alu_b_sel, alu_force_add, halted}
    localparam logic [11:0] FETCH_WAIT = 12'b0_10_0_0_0_0_00_0_0_0;
    localparam logic [11:0] FETCH_GO   = 12'b1_00_1_0_0_0_00_0_0_0;
    localparam logic [11:0] IDLE       = 12'b0_10_0_0_0_0_00_0_0_0;
    localparam logic [11:0] EXEC_R     = 12'b0_10_0_0_0_1_00_0_0_0;
    localparam logic [11:0] EXEC_I     = 12'b0_10_0_0_0_1_00_1_0_0;
    localparam logic [11:0] ADDR       = 12'b0_10_0_0_0_0_00_1_1_0;
    localparam logic [11:0] MEM_LD     = 12'b0_10_0_1_0_0_00_1_1_0;
    localparam logic [11:0] MEM_ST     = 12'b0_10_0_1_1_0_00_1_1_0;
    localparam logic [11:0] WB         = 12'b0_10_0_0_0_1_01_0_0_0;
    localparam logic [11:0] BR_TAKEN   = 12'b1_01_0_0_0_0_00_0_0_0;
    localparam logic [11:0] JUMP       = 12'b1_01_0_0_0_1_10_0_0_0;
    localparam logic [11:0] HALT       = 12'b0_10_0_0_0_0_00_0_0_1;
    localparam logic [11:0] ALL_BITS   = 12'hFFF;
    // During reset only the enables and halted are pinned.
    localparam logic [11:0] RST_MASK   = 12'b1_00_1_0_1_1_00_0_0_1;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_IL = 7'b0000000;

    typedef struct {
        logic [11:0] ctl;
        logic [11:0] mask;
        logic [31:0] instret;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    logic [11:0] act_ctl;
    assign act_ctl = {bus.pc_en, bus.pc_src, bus.ir_en, bus.mem_addr_sel, bus.mem_wren,
                      bus.rf_wr_en, bus.wb_sel, bus.alu_b_sel, bus.alu_force_add, bus.halted};

    // Drive one cycle of inputs just after the edge and queue what that cycle must show.
    task automatic step(input logic r, input logic [6:0] op, input logic bt, input logic mr,
                        input logic [11:0] ctl, input logic [11:0] mask,
                        input logic [31:0] ins, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.opcode       = op;
        bus.branch_taken = bt;
        bus.mem_ready    = mr;
        e.ctl     = ctl;
        e.mask    = mask;
        e.instret = ins;
        e.name    = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: pop one expectation per cycle on the falling edge and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ((act_ctl & e.mask) !== (e.ctl & e.mask)) begin
                    n_bad++;
                    $display("FAIL %s ctl: got %b want %b (mask %b)", e.name, act_ctl, e.ctl, e.mask);
                end
                n_cmp++;
                if (bus.instret !== e.instret) begin
                    n_bad++;
                    $display("FAIL %s instret: got %0d want %0d", e.name, bus.instret, e.instret);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: stimulus incomplete, got timeout want completion");
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        bus.opcode       = OP_R;
        bus.branch_taken = 1'b0;
        bus.mem_ready    = 1'b1;

        step(1'b1, OP_R, 1'b0, 1'b1, IDLE, RST_MASK, 32'd0, "reset");

        // R-type: 3 cycles, retires once
        step(1'b0, OP_R, 1'b0, 1'b1, FETCH_GO, ALL_BITS, 32'd0, "r_fetch");
        step(1'b0, OP_R, 1'b0, 1'b1, IDLE,     ALL_BITS, 32'd0, "r_decode");
        step(1'b0, OP_R, 1'b0, 1'b1, EXEC_R,   ALL_BITS, 32'd0, "r_exec");

        // I-ALU selects the immediate
        step(1'b0, OP_I, 1'b0, 1'b1, FETCH_GO, ALL_BITS, 32'd1, "i_fetch");
        step(1'b0, OP_I, 1'b0, 1'b1, IDLE,     ALL_BITS, 32'd1, "i_decode");
        step(1'b0, OP_I, 1'b0, 1'b1, EXEC_I,   ALL_BITS, 32'd1, "i_exec");

        // LOAD with two wait cycles in MEM
        step(1'b0, OP_LD, 1'b0, 1'b1, FETCH_GO, ALL_BITS, 32'd2, "ld_fetch");
        step(1'b0, OP_LD, 1'b0, 1'b1, IDLE,     ALL_BITS, 32'd2, "ld_decode");
        step(1'b0, OP_LD, 1'b0, 1'b1, ADDR,     ALL_BITS, 32'd2, "ld_addr");
        step(1'b0, OP_LD, 1'b0, 1'b0, MEM_LD,   ALL_BITS, 32'd2, "ld_mem_w0");
        step(1'b0, OP_LD, 1'b0, 1'b0, MEM_LD,   ALL_BITS, 32'd2, "ld_mem_w1");
        step(1'b0, OP_LD, 1'b0, 1'b1, MEM_LD,   ALL_BITS, 32'd2, "ld_mem_rdy");
        step(1'b0, OP_LD, 1'b0, 1'b1, WB,       ALL_BITS, 32'd2, "ld_wb");

        // STORE, preceded by one fetch wait cycle
        step(1'b0, OP_ST, 1'b0, 1'b0, FETCH_WAIT, ALL_BITS, 32'd3, "st_fetch_wait");
        step(1'b0, OP_ST, 1'b0, 1'b1, FETCH_GO,   ALL_BITS, 32'd3, "st_fetch");
        step(1'b0, OP_ST, 1'b0, 1'b1, IDLE,       ALL_BITS, 32'd3, "st_decode");
        step(1'b0, OP_ST, 1'b0, 1'b1, ADDR,       ALL_BITS, 32'd3, "st_addr");
        step(1'b0, OP_ST, 1'b0, 1'b1, MEM_ST,     ALL_BITS, 32'd3, "st_mem");

        // BRANCH taken then not taken
        step(1'b0, OP_BR, 1'b1, 1'b1, FETCH_GO, ALL_BITS, 32'd4, "bt_fetch");
        step(1'b0, OP_BR, 1'b1, 1'b1, IDLE,     ALL_BITS, 32'd4, "bt_decode");
        step(1'b0, OP_BR, 1'b1, 1'b1, BR_TAKEN, ALL_BITS, 32'd4, "bt_branch");
        step(1'b0, OP_BR, 1'b0, 1'b1, FETCH_GO, ALL_BITS, 32'd5, "bn_fetch");
        step(1'b0, OP_BR, 1'b0, 1'b1, IDLE,     ALL_BITS, 32'd5, "bn_decode");
        step(1'b0, OP_BR, 1'b0, 1'b1, IDLE,     ALL_BITS, 32'd5, "bn_branch");

        // JAL
        step(1'b0, OP_J, 1'b0, 1'b1, FETCH_GO, ALL_BITS, 32'd6, "j_fetch");
        step(1'b0, OP_J, 1'b0, 1'b1, IDLE,     ALL_BITS, 32'd6, "j_decode");
        step(1'b0, OP_J, 1'b0, 1'b1, JUMP,     ALL_BITS, 32'd6, "j_jump");

        // STORE abandoned by reset while waiting in MEM
        step(1'b0, OP_ST, 1'b0, 1'b1, FETCH_GO,   ALL_BITS, 32'd7, "sr_fetch");
        step(1'b0, OP_ST, 1'b0, 1'b1, IDLE,       ALL_BITS, 32'd7, "sr_decode");
        step(1'b0, OP_ST, 1'b0, 1'b1, ADDR,       ALL_BITS, 32'd7, "sr_addr");
        step(1'b0, OP_ST, 1'b0, 1'b0, MEM_ST,     ALL_BITS, 32'd7, "sr_mem");
        step(1'b1, OP_ST, 1'b0, 1'b1, IDLE,       RST_MASK, 32'd7, "sr_rst");
        step(1'b0, OP_ST, 1'b0, 1'b0, FETCH_WAIT, ALL_BITS, 32'd0, "sr_after");

        // Illegal opcode halts and stays halted
        step(1'b0, OP_IL, 1'b0, 1'b1, FETCH_GO, ALL_BITS, 32'd0, "il_fetch");
        step(1'b0, OP_IL, 1'b0, 1'b1, IDLE,     ALL_BITS, 32'd0, "il_decode");
        for (int i = 0; i < 11; i++) begin
            step(1'b0, OP_IL, i[0], i[1], HALT, ALL_BITS, 32'd0, "il_halt");
        end
        step(1'b1, OP_IL, 1'b0, 1'b1, IDLE, RST_MASK, 32'd0, "il_rst");

        // Back to normal operation after reset
        step(1'b0, OP_R, 1'b0, 1'b1, FETCH_GO,   ALL_BITS, 32'd0, "post_fetch");
        step(1'b0, OP_R, 1'b0, 1'b1, IDLE,       ALL_BITS, 32'd0, "post_decode");
        step(1'b0, OP_R, 1'b0, 1'b1, EXEC_R,     ALL_BITS, 32'd0, "post_exec");
        step(1'b0, OP_R, 1'b0, 1'b0, FETCH_WAIT, ALL_BITS, 32'd1, "post_done");

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
